// File: rtl/shift_pipe2.sv
// Two-stage pipelined 16-bit shifter/rotator with valid/ready handshake and flush.
// Stage 1 resolves count bits [1:0]; stage 2 resolves count bits [3:2].
module shift_pipe2 #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned S1_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned S2_BITS = CNT_W - S1_BITS;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  // Stage 1 payload: partially shifted data plus what stage 2 still needs
  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [S2_BITS-1:0] cnt;
    op_e                op;
  } s1_t;

  // SRA keeps the msb, so a second pass can reuse data[msb] as the fill bit
  function automatic logic [WIDTH-1:0] shift_op(
    input logic [WIDTH-1:0] d,
    input op_e              op,
    input logic [CNT_W-1:0] amt
  );
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH-1:0]   res;
    rot = {d, d} << amt;
    res = d;
    unique case (op)
      OP_ROL: res = rot[2*WIDTH-1:WIDTH];
      OP_SLL: res = d << amt;
      OP_SRA: res = WIDTH'($signed(d) >>> amt);
      OP_SRL: res = d >> amt;
      default: res = d;
    endcase
    return res;
  endfunction

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_valid_q, s2_valid_d;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic [WIDTH-1:0] s1_res_c;
  logic [WIDTH-1:0] s2_res_c;

  always_comb begin
    s1_res_c = shift_op(in_data, op_e'(in_op), CNT_W'(in_cnt[S1_BITS-1:0]));
    s2_res_c = shift_op(s1_q.data, s1_q.op, CNT_W'({s1_q.cnt, S1_BITS'(0)}));
  end

  // Handshake and next-state: flush overrides any advance
  always_comb begin
    s2_adv_c   = !s2_valid_q || out_ready;
    s1_adv_c   = !s1_valid_q || s2_adv_c;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    s2_valid_d = s2_valid_q;

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s2_res_c;
      end
    end

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.data = s1_res_c;
        s1_d.cnt  = in_cnt[CNT_W-1:S1_BITS];
        s1_d.op   = op_e'(in_op);
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_data_q  <= s2_data_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign in_ready  = s1_adv_c;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

endmodule

// File: tb/tb_shift_pipe2.sv
// Self-checking bench for shift_pipe2: directed vector table, handshake corner
// sequences and a random stream checked by an in-order scoreboard.
module tb_shift_pipe2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  shift_pipe2 dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: one bit position per iteration
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [3:0] cnt,
                                            input logic [15:0] d);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(cnt); i++) begin
      case (op)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[15], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: sampled at negedge, reflecting what the next posedge will do
  logic [15:0] exp_q[$];
  int          n_in   = 0;
  int          n_pop  = 0;
  int          n_drop = 0;
  logic        hold_chk = 1'b0;
  logic [15:0] hold_data = '0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (hold_chk) begin
      checks++;
      if (!(out_valid === 1'b1 && out_data === hold_data)) begin
        errors++;
        $display("FAIL stall_hold: valid %b data %h expected valid 1 data %h",
                 out_valid, out_data, hold_data);
      end
    end
    hold_chk  = (out_valid === 1'b1) && !out_ready && !rst && !flush;
    hold_data = out_data;
    if (rst || flush) begin
      n_drop += exp_q.size();
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: out_valid=1 data %h with nothing in flight", out_data);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          n_pop++;
          checks++;
          if (out_data !== e) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_shift(in_op, in_cnt, in_data));
        n_in++;
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    int start_in;
    int start_pop;
    int cyc;

    vecs[0]  = '{2'd0, 4'd2,  16'h8001, 16'h0006};
    vecs[1]  = '{2'd0, 4'd15, 16'h1234, 16'h091A};
    vecs[2]  = '{2'd2, 4'd15, 16'h8000, 16'hFFFF};
    vecs[3]  = '{2'd2, 4'd3,  16'h4000, 16'h0800};
    vecs[4]  = '{2'd3, 4'd12, 16'hF000, 16'h000F};
    vecs[5]  = '{2'd1, 4'd4,  16'h00FF, 16'h0FF0};
    vecs[6]  = '{2'd0, 4'd0,  16'hA5A5, 16'hA5A5};
    vecs[7]  = '{2'd1, 4'd0,  16'hA5A5, 16'hA5A5};
    vecs[8]  = '{2'd2, 4'd0,  16'hA5A5, 16'hA5A5};
    vecs[9]  = '{2'd3, 4'd0,  16'hA5A5, 16'hA5A5};
    vecs[10] = '{2'd2, 4'd4,  16'h8000, 16'hF800};
    vecs[11] = '{2'd1, 4'd15, 16'h0001, 16'h8000};
    vecs[12] = '{2'd3, 4'd15, 16'h8000, 16'h0001};
    vecs[13] = '{2'd0, 4'd5,  16'h0001, 16'h0020};
    vecs[14] = '{2'd0, 4'd6,  16'hF000, 16'h003C};
    vecs[15] = '{2'd2, 4'd14, 16'h7FFF, 16'h0001};
    vecs[16] = '{2'd2, 4'd7,  16'hC350, 16'hFF86};
    vecs[17] = '{2'd1, 4'd6,  16'h1234, 16'h8D00};
    vecs[18] = '{2'd3, 4'd9,  16'h8D00, 16'h0046};
    vecs[19] = '{2'd0, 4'd8,  16'hABCD, 16'hCDAB};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_cnt = '0; in_op = '0;
    tick(); tick();
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    rst = 1'b0;
    tick();

    // Directed table: one op at a time, exact 2-cycle latency
    for (int v = 0; v < NV; v++) begin
      in_valid = 1'b1; in_op = vecs[v].op; in_cnt = vecs[v].cnt; in_data = vecs[v].data;
      #1;
      chk($sformatf("vec%0d_in_ready", v), 16'(in_ready), 16'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", v), 16'(out_valid), 16'h0);
      tick();
      chk($sformatf("vec%0d_lat2_valid", v), 16'(out_valid), 16'h1);
      chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp);
    end
    tick();

    // Back-to-back 8 ops: 8 consecutive results
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      in_op = 2'(c); in_cnt = 4'(2 * c + 1); in_data = 16'(16'h1111 * (c + 1));
      tick();
      if (out_valid) seen++;
    end
    chk("b2b_count", 16'(seen), 16'd8);

    // Stall with in_valid held: in_ready drops, nothing lost or duplicated
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_op = 2'(c + 1); in_cnt = 4'(c + 5); in_data = 16'(16'h2468 + c);
      tick();
    end
    out_ready = 1'b0;
    in_data = 16'hBEEF; in_cnt = 4'd7; in_op = 2'd2;
    tick();
    tick();
    chk("stall_in_ready", 16'(in_ready), 16'h0);
    chk("stall_out_valid", 16'(out_valid), 16'h1);
    tick();
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stall_drained", 16'(exp_q.size()), 16'h0);

    // Flush with both stages full and an input presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd1; in_cnt = 4'd1; in_data = 16'h0101;
    tick();
    in_data = 16'h0202;
    tick();
    in_data = 16'h0303;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 16'(out_valid), 16'h0);
    chk("flush_in_ready", 16'(in_ready), 16'h1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd3; in_cnt = 4'd4; in_data = 16'hF0F0;
    tick();
    in_valid = 1'b0;
    chk("post_flush_lat1", 16'(out_valid), 16'h0);
    tick();
    chk("post_flush_lat2", 16'(out_valid), 16'h1);
    chk("post_flush_data", out_data, 16'h0F0F);
    tick();

    // Flush while an input would otherwise fire: it is dropped
    in_valid = 1'b1; in_op = 2'd0; in_cnt = 4'd3; in_data = 16'h1357;
    tick();
    in_data = 16'h2468;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();
    chk("flush_drop_idle", 16'(out_valid), 16'h0);

    // Reset mid-stream with output stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd2; in_cnt = 4'd9; in_data = 16'h9ABC;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 16'(out_valid), 16'h0);
    chk("midrst_out_data", out_data, 16'h0000);
    chk("midrst_in_ready", 16'(in_ready), 16'h1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("midrst_idle", 16'(out_valid), 16'h0);

    // Random stream, exact count of 10000 ops
    start_in  = n_in;
    start_pop = n_pop;
    cyc = 0;
    while ((n_in - start_in) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom);
      in_op     = 2'($urandom);
      tick();
      cyc++;
    end
    if (cyc >= 60000) begin
      errors++;
      $display("FAIL rand_timeout: issued %0d of 10000", n_in - start_in);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_in_count", 16'(n_in - start_in), 16'd10000);
    chk("rand_out_count", 16'(n_pop - start_pop), 16'd10000);
    chk("rand_drained", 16'(exp_q.size()), 16'h0);
    chk("total_balance", 16'(n_in - n_pop - n_drop), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
